random_state_generator_mc: RTL and testbench



---
 rtl/random_state_generator_mc.sv | 128 ++++++++++++
 tb/tb_random_state_generator_mc.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/random_state_generator_mc.sv
// Multi-channel random state generator: each channel toggles a 1-bit state whose
// phase lengths are drawn from per-state [MIN, MAX] ranges by a per-channel Galois LFSR.
module random_state_generator_mc #(
    parameter int                    CH_NUM          = 4,
    parameter int                    CNT_WIDTH       = 16,
    parameter int                    LFSR_WIDTH      = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY       = LFSR_WIDTH'(32'h80200003),
    parameter logic [LFSR_WIDTH-1:0] SEED            = LFSR_WIDTH'(32'h1),
    parameter int                    STATE_0_MIN_VAL = 100,
    parameter int                    STATE_0_MAX_VAL = 600,
    parameter int                    STATE_1_MIN_VAL = 60,
    parameter int                    STATE_1_MAX_VAL = 500
) (
    input  logic                  i_clk,
    input  logic                  i_a_rst_n,
    input  logic                  i_en,
    input  logic                  i_mode,
    input  logic                  i_seed_load,
    input  logic [LFSR_WIDTH-1:0] i_seed,
    output logic [CH_NUM-1:0]     o_state,
    output logic [CH_NUM-1:0]     o_toggle
);

    localparam logic [63:0] MIN0  = 64'(STATE_0_MIN_VAL);
    localparam logic [63:0] MIN1  = 64'(STATE_1_MIN_VAL);
    localparam logic [63:0] SPAN0 = 64'(STATE_0_MAX_VAL - STATE_0_MIN_VAL);
    localparam logic [63:0] SPAN1 = 64'(STATE_1_MAX_VAL - STATE_1_MIN_VAL);
    localparam int          RW0   = (SPAN0 == 64'd0) ? 1 : $clog2(SPAN0 + 64'd1);
    localparam int          RW1   = (SPAN1 == 64'd0) ? 1 : $clog2(SPAN1 + 64'd1);
    localparam logic [63:0] MASK0 = (64'd1 << RW0) - 64'd1;
    localparam logic [63:0] MASK1 = (64'd1 << RW1) - 64'd1;
    localparam logic [CNT_WIDTH-1:0] CNT_MIN0 = CNT_WIDTH'(STATE_0_MIN_VAL);
    localparam logic [CNT_WIDTH-1:0] CNT_MIN1 = CNT_WIDTH'(STATE_1_MIN_VAL);

    if (CH_NUM < 1 || CH_NUM > 16) begin : g_bad_ch_num
        $error("CH_NUM must lie in 1..16");
    end
    if (STATE_0_MIN_VAL < 1 || STATE_1_MIN_VAL < 1) begin : g_bad_min
        $error("state minimum durations must be >= 1");
    end
    if (STATE_0_MAX_VAL < STATE_0_MIN_VAL || STATE_1_MAX_VAL < STATE_1_MIN_VAL) begin : g_bad_max
        $error("state maximum durations must be >= their minimum");
    end
    if (64'(STATE_0_MAX_VAL) >= (64'd1 << CNT_WIDTH) || 64'(STATE_1_MAX_VAL) >= (64'd1 << CNT_WIDTH)) begin : g_bad_cnt
        $error("maximum durations must fit in CNT_WIDTH");
    end
    if (!LFSR_POLY[LFSR_WIDTH-1]) begin : g_bad_poly
        $error("LFSR_POLY must have its top bit set so the LFSR cannot reach zero");
    end

    function automatic logic [LFSR_WIDTH-1:0] seed_ch(input int k, input logic [LFSR_WIDTH-1:0] base);
        logic [31:0]           mix;
        logic [LFSR_WIDTH-1:0] s;
        mix = 32'(k + 1) * 32'h9E3779B9;
        s   = base ^ LFSR_WIDTH'(mix);
        return (s == '0) ? LFSR_WIDTH'(1) : s;
    endfunction

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : '0);
    endfunction

    // Out-of-range draws fold back by one span, which is enough because mask <= 2*SPAN+1.
    function automatic logic [CNT_WIDTH-1:0] draw(input logic [LFSR_WIDTH-1:0] l,
                                                   input logic [63:0] min_v,
                                                   input logic [63:0] span,
                                                   input logic [63:0] mask);
        logic [63:0] r;
        logic [63:0] d;
        r = 64'(l) & mask;
        if (r > span) begin
            r = r - (span + 64'd1);
        end
        d = min_v + r;
        return d[CNT_WIDTH-1:0];
    endfunction

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        logic                  state_q,  state_d;
        logic                  toggle_q, toggle_d;
        logic [CNT_WIDTH-1:0]  cnt_q,    cnt_d;
        logic [LFSR_WIDTH-1:0] lfsr_q,   lfsr_d;

        always_comb begin
            state_d  = state_q;
            toggle_d = 1'b0;
            cnt_d    = cnt_q;
            lfsr_d   = lfsr_q;
            if (i_seed_load) begin
                lfsr_d  = seed_ch(gi, i_seed);
                state_d = 1'b0;
                cnt_d   = CNT_MIN0;
            end else if (i_en) begin
                if (cnt_q > CNT_WIDTH'(1)) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end else begin
                    state_d  = ~state_q;
                    toggle_d = 1'b1;
                    if (i_mode) begin
                        cnt_d = state_q ? CNT_MIN0 : CNT_MIN1;
                    end else begin
                        cnt_d  = state_q ? draw(lfsr_q, MIN0, SPAN0, MASK0)
                                         : draw(lfsr_q, MIN1, SPAN1, MASK1);
                        lfsr_d = lfsr_step(lfsr_q);
                    end
                end
            end
        end

        always_ff @(posedge i_clk or negedge i_a_rst_n) begin
            if (!i_a_rst_n) begin
                state_q  <= 1'b0;
                toggle_q <= 1'b0;
                cnt_q    <= CNT_MIN0;
                lfsr_q   <= seed_ch(gi, SEED);
            end else begin
                state_q  <= state_d;
                toggle_q <= toggle_d;
                cnt_q    <= cnt_d;
                lfsr_q   <= lfsr_d;
            end
        end

        assign o_state[gi]  = state_q;
        assign o_toggle[gi] = toggle_q;
    end

endmodule

// File: tb/tb_random_state_generator_mc.sv
// Self-checking bench for random_state_generator_mc: an edge-schedule model predicts
// every toggle; a second instance exercises single-cycle state-1 runs.
module tb_random_state_generator_mc;

    localparam int          CH   = 4;
    localparam int          MIN0 = 100;
    localparam int          MAX0 = 600;
    localparam int          MIN1 = 60;
    localparam int          MAX1 = 500;
    localparam int unsigned POLY = 32'h80200003;
    localparam int unsigned SEED = 32'h1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic          mode = 1'b0;
    logic          seed_load = 1'b0;
    logic [31:0]   seed = '0;
    logic          en1 = 1'b1;
    logic          mode1 = 1'b0;
    logic          load1 = 1'b0;
    logic [CH-1:0] o_state, o_toggle, o_state1, o_toggle1;

    int    vectors = 0;
    int    miscompares = 0;
    longint cyc = 0;

    always #5 clk = ~clk;

    random_state_generator_mc dut (
        .i_clk(clk), .i_a_rst_n(rst_n), .i_en(en), .i_mode(mode),
        .i_seed_load(seed_load), .i_seed(seed),
        .o_state(o_state), .o_toggle(o_toggle)
    );

    random_state_generator_mc #(.STATE_1_MIN_VAL(1), .STATE_1_MAX_VAL(1)) dut1 (
        .i_clk(clk), .i_a_rst_n(rst_n), .i_en(en1), .i_mode(mode1),
        .i_seed_load(load1), .i_seed(seed),
        .o_state(o_state1), .o_toggle(o_toggle1)
    );

    // Model: per channel, the enabled-cycle count at which the next toggle is due.
    int unsigned   m_lfsr [CH];
    longint        m_edge [CH];
    longint        m_en_cnt;
    logic [CH-1:0] m_state, m_tog;

    function automatic int unsigned seed_ch(int k, int unsigned b);
        int unsigned kk, s;
        kk = k + 1;
        s  = b ^ (kk * 32'h9E3779B9);
        if (s == 0) s = 1;
        return s;
    endfunction

    function automatic int draw(int k, logic s, logic md);
        int mn, mx, d, rw;
        int unsigned span, r;
        mn = s ? MIN1 : MIN0;
        mx = s ? MAX1 : MAX0;
        if (md) return mn;
        span = mx - mn;
        if (span == 0) begin
            d = mn;
        end else begin
            rw = $clog2(span + 1);
            r  = m_lfsr[k] & ((32'd1 << rw) - 32'd1);
            if (r > span) r = r - (span + 1);
            d  = mn + int'(r);
        end
        m_lfsr[k] = (m_lfsr[k] >> 1) ^ (m_lfsr[k][0] ? POLY : 32'd0);
        return d;
    endfunction

    function automatic void model_load(int unsigned b);
        for (int k = 0; k < CH; k++) begin
            m_lfsr[k] = seed_ch(k, b);
            m_edge[k] = MIN0;
        end
        m_state  = '0;
        m_tog    = '0;
        m_en_cnt = 0;
    endfunction

    function automatic void model_step();
        m_tog = '0;
        if (seed_load) begin
            model_load(seed);
        end else if (en) begin
            m_en_cnt++;
            for (int k = 0; k < CH; k++) begin
                if (m_en_cnt == m_edge[k]) begin
                    m_state[k] = ~m_state[k];
                    m_tog[k]   = 1'b1;
                    m_edge[k]  = m_edge[k] + draw(k, m_state[k], mode);
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_step();
        #1;
    endtask

    task automatic test_reset();
        en = 1'b0; mode = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (o_state !== '0 || o_toggle !== '0) begin
            miscompares++;
            $display("FAIL reset_async state=%b tog=%b required 0000/0000", o_state, o_toggle);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (o_state !== '0 || o_toggle !== '0 || o_state1 !== '0 || o_toggle1 !== '0) begin
            miscompares++;
            $display("FAIL reset_hold state=%b tog=%b state1=%b tog1=%b required all 0", o_state, o_toggle, o_state1, o_toggle1);
        end
        rst_n = 1'b1;
        model_load(SEED);
        $display("test_reset: outputs cleared under reset");
    endtask

    task automatic test_fixed_mode();
        int t_tog [3];
        int ntog = 0;
        int exp_t [3] = '{100, 160, 260};
        mode = 1'b1; en = 1'b1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            vectors++;
            if (o_state !== m_state || o_toggle !== m_tog) begin
                miscompares++;
                $display("FAIL fixed_trace tick=%0d state=%b required %b tog=%b required %b", i, o_state, m_state, o_toggle, m_tog);
            end
            if (o_toggle[0] && ntog < 3) begin
                t_tog[ntog] = i;
                ntog++;
            end
        end
        for (int j = 0; j < 3; j++) begin
            vectors++;
            if (j >= ntog || t_tog[j] != exp_t[j]) begin
                miscompares++;
                $display("FAIL fixed_toggle_time idx=%0d got %0d required %0d", j, (j < ntog) ? t_tog[j] : -1, exp_t[j]);
            end
        end
        $display("test_fixed_mode: %0d toggles timed on channel 0", ntog);
    endtask

    task automatic test_enable_gap();
        int  wall = 1;
        logic done = 1'b0;
        mode = 1'b1; en = 1'b1;
        seed_load = 1'b1; seed = SEED;
        tick();
        seed_load = 1'b0;
        vectors++;
        if (o_state !== '0 || o_toggle !== '0) begin
            miscompares++;
            $display("FAIL gap_load state=%b tog=%b required 0", o_state, o_toggle);
        end
        for (int i = 1; i <= 300; i++) begin
            en = (i < 51 || i > 87);
            tick();
            vectors++;
            if (o_state !== m_state || o_toggle !== m_tog || (!en && o_toggle !== '0)) begin
                miscompares++;
                $display("FAIL gap_trace tick=%0d en=%b state=%b required %b tog=%b required %b", i, en, o_state, m_state, o_toggle, m_tog);
            end
            if (!done && o_state[0] == 1'b0) wall++;
            else done = 1'b1;
        end
        en = 1'b1;
        vectors++;
        if (wall != 137) begin
            miscompares++;
            $display("FAIL gap_run_length got %0d required 137", wall);
        end
        $display("test_enable_gap: state-0 run lasted %0d wall cycles", wall);
    endtask

    task automatic test_random();
        int          run [CH];
        logic        valid [CH];
        int          ntog [CH];
        longint unsigned sig [CH];
        for (int k = 0; k < CH; k++) begin
            run[k] = 0; valid[k] = 1'b0; ntog[k] = 0; sig[k] = 0;
        end
        for (int i = 1; i <= 20000; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            mode = ($urandom_range(0, 49) == 0);
            tick();
            vectors++;
            if (o_state !== m_state || o_toggle !== m_tog) begin
                miscompares++;
                $display("FAIL random_trace tick=%0d state=%b required %b tog=%b required %b", i, o_state, m_state, o_toggle, m_tog);
            end
            for (int k = 0; k < CH; k++) begin
                if (en) run[k]++;
                if (o_toggle[k]) begin
                    if (valid[k]) begin
                        vectors++;
                        if (o_state[k] ? (run[k] < MIN0 || run[k] > MAX0) : (run[k] < MIN1 || run[k] > MAX1)) begin
                            miscompares++;
                            $display("FAIL random_run_range ch=%0d ended_state=%0d len=%0d", k, !o_state[k], run[k]);
                        end
                    end
                    valid[k] = 1'b1;
                    run[k]   = 0;
                    ntog[k]++;
                    sig[k]   = sig[k] * 64'd31 + 64'(i);
                end
            end
        end
        en = 1'b1; mode = 1'b0;
        for (int a = 0; a < CH; a++) begin
            vectors++;
            if (ntog[a] < 10) begin
                miscompares++;
                $display("FAIL random_activity ch=%0d toggles=%0d required >=10", a, ntog[a]);
            end
            for (int b = a + 1; b < CH; b++) begin
                vectors++;
                if (sig[a] == sig[b]) begin
                    miscompares++;
                    $display("FAIL random_distinct ch%0d and ch%0d share toggle sequence %0h", a, b, sig[a]);
                end
            end
        end
        $display("test_random: toggles per channel %0d %0d %0d %0d", ntog[0], ntog[1], ntog[2], ntog[3]);
    endtask

    task automatic test_seed_load();
        logic found = 1'b0;
        logic [2*CH-1:0] q_ref [$];
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            for (int k = 0; k < CH; k++) begin
                if (m_en_cnt + 1 == m_edge[k]) found = 1'b1;
            end
            if (!found) begin
                tick();
                vectors++;
                if (o_state !== m_state || o_toggle !== m_tog) begin
                    miscompares++;
                    $display("FAIL seed_pre_trace state=%b required %b tog=%b required %b", o_state, m_state, o_toggle, m_tog);
                end
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL seed_expiry_search no pending expiry within 3000 cycles required one");
        end
        for (int pass = 0; pass < 2; pass++) begin
            seed_load = 1'b1; seed = 32'hDEADBEEF;
            tick();
            seed_load = 1'b0;
            vectors++;
            if (o_state !== '0 || o_toggle !== '0) begin
                miscompares++;
                $display("FAIL seed_load_clear pass=%0d state=%b tog=%b required 0", pass, o_state, o_toggle);
            end
            for (int i = 0; i < 1500; i++) begin
                tick();
                if (pass == 0) q_ref.push_back({m_state, m_tog});
                vectors++;
                if ({o_state, o_toggle} !== q_ref[i]) begin
                    miscompares++;
                    $display("FAIL seed_trace pass=%0d tick=%0d got %b required %b", pass, i, {o_state, o_toggle}, q_ref[i]);
                end
            end
        end
        $display("test_seed_load: two reloads with DEADBEEF traced %0d cycles each", q_ref.size());
    endtask

    task automatic test_async_reset();
        int   ft [CH];
        logic found = 1'b0;
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            vectors++;
            if (o_state !== m_state || o_toggle !== m_tog) begin
                miscompares++;
                $display("FAIL arst_pre_trace state=%b required %b", o_state, m_state);
            end
            found = m_state[0];
        end
        vectors++;
        if (!found || o_state[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_state1_search state0=%b required 1", o_state[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (o_state !== '0 || o_toggle !== '0) begin
            miscompares++;
            $display("FAIL arst_no_clock state=%b tog=%b required 0", o_state, o_toggle);
        end
        #2 rst_n = 1'b1;
        model_load(SEED);
        for (int k = 0; k < CH; k++) ft[k] = -1;
        for (int i = 1; i <= 700; i++) begin
            tick();
            vectors++;
            if (o_state !== m_state || o_toggle !== m_tog) begin
                miscompares++;
                $display("FAIL arst_post_trace tick=%0d state=%b required %b", i, o_state, m_state);
            end
            for (int k = 0; k < CH; k++) begin
                if (o_toggle[k] && ft[k] < 0) ft[k] = i;
            end
        end
        for (int k = 0; k < CH; k++) begin
            vectors++;
            if (ft[k] != MIN0) begin
                miscompares++;
                $display("FAIL arst_first_run ch=%0d got %0d required %0d", k, ft[k], MIN0);
            end
        end
        $display("test_async_reset: first runs after release %0d %0d %0d %0d", ft[0], ft[1], ft[2], ft[3]);
    endtask

    task automatic test_short_state1();
        logic [CH-1:0] prev1 = '0;
        int   fall_t [CH];
        logic first [CH];
        int   rises [CH];
        int   len;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_load(SEED);
        en = 1'b1; mode = 1'b0;
        for (int k = 0; k < CH; k++) begin
            fall_t[k] = 0; first[k] = 1'b1; rises[k] = 0;
        end
        for (int i = 1; i <= 4000; i++) begin
            tick();
            vectors++;
            if (o_toggle1 !== (o_state1 ^ prev1)) begin
                miscompares++;
                $display("FAIL short_toggle tick=%0d tog=%b required %b", i, o_toggle1, o_state1 ^ prev1);
            end
            for (int k = 0; k < CH; k++) begin
                if (prev1[k]) begin
                    vectors++;
                    if (o_state1[k] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL short_state1_len ch=%0d tick=%0d state1 held longer than 1 cycle", k, i);
                    end
                    fall_t[k] = i;
                end else if (o_state1[k]) begin
                    len = i - fall_t[k];
                    vectors++;
                    if (first[k] ? (len != MIN0) : (len < MIN0 || len > MAX0)) begin
                        miscompares++;
                        $display("FAIL short_state0_len ch=%0d first=%0d len=%0d required %0d..%0d", k, first[k], len, MIN0, first[k] ? MIN0 : MAX0);
                    end
                    first[k] = 1'b0;
                    rises[k]++;
                end
            end
            prev1 = o_state1;
        end
        for (int k = 0; k < CH; k++) begin
            vectors++;
            if (rises[k] < 5) begin
                miscompares++;
                $display("FAIL short_activity ch=%0d rises=%0d required >=5", k, rises[k]);
            end
        end
        $display("test_short_state1: rises per channel %0d %0d %0d %0d", rises[0], rises[1], rises[2], rises[3]);
    endtask

    initial begin
        test_reset();
        test_fixed_mode();
        test_enable_gap();
        test_random();
        test_seed_load();
        test_async_reset();
        test_short_state1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
